// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single regfile write port between the CPU writeback stage and the
// I/O peripheral: fixed CPU priority with a starvation guard for I/O.
module regfile_write_arbiter #(
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clock,
    input  logic             ctrl_reset_n,
    input  logic             cpu_valid,
    input  logic [4:0]       cpu_rd,
    input  logic [31:0]      cpu_data,
    output logic             cpu_ready,
    input  logic             io_valid,
    input  logic [4:0]       io_rd,
    input  logic [31:0]      io_data,
    output logic             io_ready,
    output logic             ctrl_writeEnable,
    output logic [4:0]       ctrl_writeReg,
    output logic [31:0]      data_writeReg,
    output logic [CNT_W-1:0] starve_events
);

    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic {
        PRIO_CPU,
        PRIO_IO
    } state_e;

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  io_wait_q, io_wait_d;
    logic [CNT_W-1:0]   starve_q, starve_d;
    logic               we_q, we_d;
    logic [4:0]         addr_q, addr_d;
    logic [31:0]        data_q, data_d;

    logic cpu_xfer;
    logic io_xfer;
    logic io_blocked;

    // Ready depends only on state and the other side's valid, never on its own valid.
    always_comb begin
        cpu_ready = 1'b0;
        io_ready  = 1'b0;
        if (ctrl_reset_n) begin
            if (state_q == PRIO_CPU) begin
                cpu_ready = 1'b1;
                io_ready  = !cpu_valid;
            end else begin
                io_ready  = 1'b1;
                cpu_ready = !io_valid;
            end
        end
    end

    assign cpu_xfer   = cpu_valid && cpu_ready;
    assign io_xfer    = io_valid && io_ready;
    assign io_blocked = io_valid && !io_ready;

    always_comb begin
        state_d   = state_q;
        io_wait_d = io_wait_q;
        starve_d  = starve_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;

        if (io_xfer || !io_valid) begin
            io_wait_d = '0;
        end else if (io_blocked && (io_wait_q != WAIT_W'(MAX_WAIT))) begin
            io_wait_d = io_wait_q + WAIT_W'(1);
        end

        case (state_q)
            PRIO_CPU: begin
                if (io_blocked && (io_wait_q == WAIT_W'(MAX_WAIT - 1))) begin
                    state_d = PRIO_IO;
                    if (starve_q != '1) begin
                        starve_d = starve_q + CNT_W'(1);
                    end
                end
            end
            PRIO_IO: begin
                if (io_xfer || !io_valid) begin
                    state_d = PRIO_CPU;
                end
            end
            default: state_d = PRIO_CPU;
        endcase

        // Writes to r0 still complete the handshake but never assert the enable.
        if (cpu_xfer) begin
            we_d   = (cpu_rd != '0);
            addr_d = cpu_rd;
            data_d = cpu_data;
        end else if (io_xfer) begin
            we_d   = (io_rd != '0);
            addr_d = io_rd;
            data_d = io_data;
        end
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            state_q   <= PRIO_CPU;
            io_wait_q <= '0;
            starve_q  <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            io_wait_q <= io_wait_d;
            starve_q  <= starve_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
        end
    end

    assign ctrl_writeEnable = we_q;
    assign ctrl_writeReg    = addr_q;
    assign data_writeReg    = data_q;
    assign starve_events    = starve_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed and randomized checks of regfile_write_arbiter against a loss-counting
// reference model of the arbitration rules.
module tb_regfile_write_arbiter;

    localparam int unsigned MAX_WAIT = 4;
    localparam int unsigned CNT_W    = 3;

    logic             clock;
    logic             ctrl_reset_n;
    logic             cpu_valid;
    logic [4:0]       cpu_rd;
    logic [31:0]      cpu_data;
    logic             cpu_ready;
    logic             io_valid;
    logic [4:0]       io_rd;
    logic [31:0]      io_data;
    logic             io_ready;
    logic             ctrl_writeEnable;
    logic [4:0]       ctrl_writeReg;
    logic [31:0]      data_writeReg;
    logic [CNT_W-1:0] starve_events;

    int errors = 0;
    int checks = 0;

    // Reference model: consecutive I/O losses; a full MAX_WAIT of losses forces one I/O win.
    int          m_losses;
    int          m_starve;
    logic        m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic        cpu_held, io_held;

    regfile_write_arbiter #(
        .MAX_WAIT (MAX_WAIT),
        .CNT_W    (CNT_W)
    ) dut (
        .clock            (clock),
        .ctrl_reset_n     (ctrl_reset_n),
        .cpu_valid        (cpu_valid),
        .cpu_rd           (cpu_rd),
        .cpu_data         (cpu_data),
        .cpu_ready        (cpu_ready),
        .io_valid         (io_valid),
        .io_rd            (io_rd),
        .io_data          (io_data),
        .io_ready         (io_ready),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .starve_events    (starve_events)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_losses = 0;
        m_starve = 0;
        m_we     = 1'b0;
        m_addr   = '0;
        m_data   = '0;
        cpu_held = 1'b0;
        io_held  = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".we"},     32'(ctrl_writeEnable), 32'(m_we));
        check({tag, ".addr"},   32'(ctrl_writeReg),    32'(m_addr));
        check({tag, ".data"},   data_writeReg,         m_data);
        check({tag, ".starve"}, 32'(starve_events),    32'(m_starve));
    endtask

    // Called #1 after a rising edge: drive, check readys, clock, check registered outputs.
    task automatic step(input string tag,
                        input logic cv, input logic [4:0] cr, input logic [31:0] cd,
                        input logic iv, input logic [4:0] ir, input logic [31:0] id);
        logic forced, exp_cr, exp_ir, cx, ix;
        cpu_valid = cv; cpu_rd = cr; cpu_data = cd;
        io_valid  = iv; io_rd  = ir; io_data  = id;
        #1;
        forced = (m_losses == int'(MAX_WAIT));
        exp_cr = forced ? !iv : 1'b1;
        exp_ir = forced ? 1'b1 : !cv;
        check({tag, ".cpu_ready"}, 32'(cpu_ready), 32'(exp_cr));
        check({tag, ".io_ready"},  32'(io_ready),  32'(exp_ir));
        cx = cv && exp_cr;
        ix = iv && exp_ir;
        cpu_held = cv && !exp_cr;
        io_held  = iv && !exp_ir;
        @(posedge clock);
        if (cx) begin
            m_we = (cr != 5'd0); m_addr = cr; m_data = cd;
        end else if (ix) begin
            m_we = (ir != 5'd0); m_addr = ir; m_data = id;
        end else begin
            m_we = 1'b0;
        end
        if (!iv || ix) m_losses = 0;
        else begin
            m_losses++;
            if (m_losses == int'(MAX_WAIT) && m_starve < (1 << CNT_W) - 1) m_starve++;
        end
        #1;
        check_outputs(tag);
    endtask

    initial begin
        int base;
        logic        cv, iv;
        logic [4:0]  cr, ir;
        logic [31:0] cd, id;

        ctrl_reset_n = 1'b0;
        cpu_valid = 1'b0; cpu_rd = '0; cpu_data = '0;
        io_valid  = 1'b1; io_rd  = '0; io_data  = '0;
        model_reset();
        #3;
        check("reset.cpu_ready", 32'(cpu_ready), 32'd0);
        check("reset.io_ready",  32'(io_ready),  32'd0);
        check_outputs("reset");
        io_valid = 1'b0;
        @(posedge clock);
        #1;
        ctrl_reset_n = 1'b1;

        // CPU alone
        step("t1", 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        check("t1.data_abs", data_writeReg, 32'hDEADBEEF);
        check("t1.addr_abs", 32'(ctrl_writeReg), 32'd5);

        // I/O alone
        step("t3", 1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 32'd7);
        check("t3.data_abs", data_writeReg, 32'd7);
        check("t3.starve_abs", 32'(starve_events), 32'd0);

        // r0 is accepted but never enabled
        step("t4", 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'd0);
        check("t4.we_abs", 32'(ctrl_writeEnable), 32'd0);

        // Continuous contention: 2 full periods of 4 CPU wins then 1 I/O win
        base = int'(starve_events);
        for (int i = 0; i < 10; i++) begin
            step("t2", 1'b1, 5'd3, 32'(100 + i), 1'b1, 5'd1, 32'h55);
            if (i == 4) check("t2.io_won_addr", 32'(ctrl_writeReg), 32'd1);
        end
        check("t2.starve_delta", 32'(starve_events), 32'(base + 2));

        // Starve counter saturation at 7
        for (int i = 0; i < 35; i++) step("sat", 1'b1, 5'd3, 32'(i), 1'b1, 5'd1, 32'h66);
        check("sat.starve_abs", 32'(starve_events), 32'd7);

        // I/O withdraws while forced; CPU must regain priority
        for (int i = 0; i < 4; i++) step("t6a", 1'b1, 5'd3, 32'(i), 1'b1, 5'd2, 32'h77);
        step("t6b", 1'b1, 5'd4, 32'h44, 1'b0, 5'd2, 32'h77);
        check("t6.cpu_won_addr", 32'(ctrl_writeReg), 32'd4);
        step("t6c", 1'b1, 5'd6, 32'h66, 1'b1, 5'd2, 32'h77);

        // Asynchronous reset mid-cycle with a transfer pending
        step("t5pre", 1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0);
        cpu_valid = 1'b1; cpu_rd = 5'd10; cpu_data = 32'hA5A5A5A5;
        #2;
        ctrl_reset_n = 1'b0;
        model_reset();
        #1;
        check("t5.cpu_ready", 32'(cpu_ready), 32'd0);
        check("t5.io_ready",  32'(io_ready),  32'd0);
        check_outputs("t5.async");
        @(posedge clock);
        #1;
        check_outputs("t5.held");
        ctrl_reset_n = 1'b1;
        step("t5post", 1'b1, 5'd11, 32'hB0B0, 1'b1, 5'd12, 32'hC0C0);
        check("t5.first_cpu", 32'(ctrl_writeReg), 32'd11);

        // Randomized traffic; blocked requesters hold rd/data and usually stay valid
        cv = 1'b0; iv = 1'b0; cr = '0; ir = '0; cd = '0; id = '0;
        for (int i = 0; i < 400; i++) begin
            if (cpu_held) cv = ($urandom_range(0, 9) != 0);
            else begin
                cv = ($urandom_range(0, 2) != 0);
                cr = 5'($urandom_range(0, 31));
                cd = $urandom;
            end
            if (io_held) iv = ($urandom_range(0, 9) != 0);
            else begin
                iv = ($urandom_range(0, 2) != 0);
                ir = ($urandom_range(0, 3) == 0) ? cr : 5'($urandom_range(0, 31));
                id = $urandom;
            end
            step("rand", cv, cr, cd, iv, ir, id);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
